// File: rtl/sim_param_sequencer_if.sv
// Host-side bus of the parameter sequencer: write strobe, commit strobe,
// active parameter bank and status pulses.
// Optional readback port is present when PARAM_READBACK_EN is defined.
interface sim_param_sequencer_if;
    logic         wr_trig;
    logic [3:0]   wr_addr;
    logic [31:0]  wr_data;
    logic         commit_trig;
    logic [255:0] params_flat;
    logic         busy;
    logic         commit_done;
    logic         wr_err;
`ifdef PARAM_READBACK_EN
    logic [2:0]   rd_addr;
    logic [31:0]  rd_data;
`endif

    modport master (
        output wr_trig, wr_addr, wr_data, commit_trig,
        input  params_flat, busy, commit_done, wr_err
`ifdef PARAM_READBACK_EN
        , output rd_addr, input rd_data
`endif
    );

    modport slave (
        input  wr_trig, wr_addr, wr_data, commit_trig,
        output params_flat, busy, commit_done, wr_err
`ifdef PARAM_READBACK_EN
        , input rd_addr, output rd_data
`endif
    );
endinterface

// File: rtl/sim_param_sequencer.sv
// Double-buffered simulation parameter bank. The host writes a shadow bank
// in the clk domain; a commit request copies the whole shadow bank into the
// active bank on the first sim_clk rising edge seen after the request, so
// params_flat only ever changes atomically and in step with the simulation.
// Optional feature macro: PARAM_READBACK_EN (registered shadow readback).
module sim_param_sequencer #(
    parameter int NSLOT = 8
) (
    input  logic clk,
    input  logic reset_global,
    input  logic sim_clk,
    sim_param_sequencer_if.slave bus
);
    // Slots: 0 tau, 1 gain, 2 gamma_dyn, 3 gamma_sta, 4 pps_coef_Ia,
    //        5 i_gain_MN, 6 len_bic_pxi, 7 trigger_input
    localparam logic [NSLOT-1:0][31:0] RST_VAL = {
        32'h0000_0000, 32'h3F66_6666, 32'h0000_0001, 32'h3F66_6666,
        32'h42A0_0000, 32'h42A0_0000, 32'h0000_0000, 32'h0000_0001
    };

    typedef enum logic [1:0] {IDLE, PENDING, COMMIT} state_t;

    state_t                    state_q, state_d;
    logic [NSLOT-1:0][31:0]    shadow_q, active_q;
    logic [2:0]                sync_q;
    logic                      sim_rise;
    logic                      addr_ok, wr_ok, wr_bad;
    logic                      commit_done_q, wr_err_q;

    assign sim_rise = sync_q[1] & ~sync_q[2];
    assign addr_ok  = (bus.wr_addr < 4'(NSLOT));
    // Writes land only while idle; a write in the commit window would tear
    // the snapshot, so it is rejected like an out-of-range address.
    assign wr_ok    = bus.wr_trig && addr_ok && (state_q == IDLE);
    assign wr_bad   = bus.wr_trig && !wr_ok;

    // Two-flop synchroniser for sim_clk plus one flop for edge detection.
    always_ff @(posedge clk or posedge reset_global) begin
        if (reset_global) sync_q <= '0;
        else              sync_q <= {sync_q[1:0], sim_clk};
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset_global) begin
        if (reset_global) state_q <= IDLE;
        else              state_q <= state_d;
    end

    // Next-state logic; a sim_rise coincident with commit_trig is seen in
    // IDLE and therefore ignored, so the commit waits for the next edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.commit_trig) state_d = PENDING;
            PENDING: if (sim_rise)        state_d = COMMIT;
            COMMIT:                       state_d = IDLE;
            default:                      state_d = IDLE;
        endcase
    end

    // Shadow bank: host writes, accepted only in IDLE.
    always_ff @(posedge clk or posedge reset_global) begin
        if (reset_global)  shadow_q <= RST_VAL;
        else if (wr_ok)    shadow_q[bus.wr_addr[2:0]] <= bus.wr_data;
    end

    // Active bank: whole-bank copy leaving COMMIT, done pulse alongside.
    always_ff @(posedge clk or posedge reset_global) begin
        if (reset_global) begin
            active_q      <= RST_VAL;
            commit_done_q <= 1'b0;
        end else begin
            commit_done_q <= (state_q == COMMIT);
            if (state_q == COMMIT) active_q <= shadow_q;
        end
    end

    // Rejected-write pulse, one cycle after the offending strobe.
    always_ff @(posedge clk or posedge reset_global) begin
        if (reset_global) wr_err_q <= 1'b0;
        else              wr_err_q <= wr_bad;
    end

`ifdef PARAM_READBACK_EN
    logic [31:0] rd_data_q;

    // Registered shadow readback, one cycle latency.
    always_ff @(posedge clk or posedge reset_global) begin
        if (reset_global) rd_data_q <= '0;
        else              rd_data_q <= shadow_q[bus.rd_addr];
    end

    assign bus.rd_data = rd_data_q;
`endif

    assign bus.params_flat = active_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.commit_done = commit_done_q;
    assign bus.wr_err      = wr_err_q;
endmodule

// File: doc/sim_param_sequencer.md
SIM_PARAM_SEQUENCER -- requirements
Module: sim_param_sequencer

Interface
REQ-001 SHALL have parameter NSLOT, default 8: number of 32-bit parameter slots (fixed 8 in this revision).
REQ-002 SHALL have port clk, input, 1 bit: system clock, clk1 domain.
REQ-003 SHALL have port reset_global, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port sim_clk, input, 1 bit: simulation clock; asynchronous to clk; commit timing reference.
REQ-005 SHALL have port wr_trig, input, 1 bit: single-cycle host write strobe in the clk domain.
REQ-006 SHALL have port wr_addr, input, 4 bits: slot index.
REQ-007 SHALL have port wr_data, input, 32 bits: {ep02wire, ep01wire} value.
REQ-008 SHALL have port commit_trig, input, 1 bit: single-cycle commit request strobe.
REQ-009 SHALL have port params_flat, output, 256 bits: active slots; slot k occupies bits [32k+31:32k].
REQ-010 SHALL have port busy, output, 1 bit: high while a commit is pending.
REQ-011 SHALL have port commit_done, output, 1 bit: one-cycle pulse when the active bank updates.
REQ-012 SHALL have port wr_err, output, 1 bit: one-cycle pulse when a write is rejected.

Function
REQ-013 SHALL hold two banks: shadow (host-written) and active (drives params_flat); slots: 0 tau, 1 gain, 2 gamma_dyn, 3 gamma_sta, 4 pps_coef_Ia, 5 i_gain_MN, 6 len_bic_pxi, 7 trigger_input.
REQ-014 SHALL synchronise sim_clk through two flops, then rising-edge detect into sim_rise (one clk cycle wide).
REQ-015 SHALL implement FSM IDLE -> PENDING -> COMMIT -> IDLE.
REQ-016 IDLE: wr_trig with wr_addr<8 SHALL write wr_data into shadow[wr_addr] at that clk edge.
REQ-017 wr_trig with wr_addr>=8 in any state SHALL leave both banks unchanged and pulse wr_err the next cycle.
REQ-018 IDLE: commit_trig SHALL go to PENDING; busy SHALL rise the next cycle.
REQ-019 PENDING: sim_rise SHALL go to COMMIT. A sim_rise in the same cycle as commit_trig SHALL NOT count; commit waits for the next sim_rise.
REQ-020 COMMIT (one cycle): SHALL copy all 8 shadow slots to active atomically; commit_done SHALL pulse the following cycle; SHALL return to IDLE.
REQ-021 params_flat SHALL change only in the cycle after COMMIT, never partially.
REQ-022 wr_trig in PENDING or COMMIT SHALL be rejected (wr_err pulse, shadow unchanged).
REQ-023 commit_trig in PENDING or COMMIT SHALL be ignored without error.
REQ-024 Simultaneous wr_trig and commit_trig in IDLE SHALL apply the write and then enter PENDING; the commit SHALL include the write.
REQ-025 Commit latency SHALL be at most 1 sim_clk period + 4 clk cycles from commit_trig.

Reset
REQ-026 reset_global SHALL asynchronously force state IDLE, busy=0, commit_done=0, wr_err=0, synchroniser flops=0.
REQ-027 Reset values for slots 0..7, in both banks, SHALL be: 0x00000001, 0x00000000, 0x42A00000, 0x42A00000, 0x3F666666, 0x00000001, 0x3F666666, 0x00000000.
REQ-028 Reset during PENDING SHALL abandon the commit; no commit_done SHALL follow reset release.

Configuration
REQ-029 Macro PARAM_READBACK_EN, when defined, SHALL add port rd_addr (input, 3 bits) and port rd_data (output, 32 bits).
REQ-030 With PARAM_READBACK_EN, rd_data SHALL be registered shadow[rd_addr] with 1-cycle latency, and 0 in reset.
REQ-031 Without PARAM_READBACK_EN, rd_addr and rd_data SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-032 Reset, then sample params_flat -> slots equal the REQ-027 values; busy=0.
REQ-033 Write slot1=0x00000040, then commit_trig -> params_flat[63:32] stays 0 until the first post-commit sim_rise; it becomes 0x40 in the cycle after COMMIT, with one commit_done pulse.
REQ-034 Write slots 2 and 3 = 0x42C80000, then commit -> both slots change in the same clk cycle.
REQ-035 Write to wr_addr=9, and a write while busy=1 -> wr_err pulses each time; shadow is unchanged; after commit, params_flat is unchanged.
REQ-036 wr_trig(slot7=1) and commit_trig in the same cycle -> committed slot7=1.
REQ-037 Assert reset_global during PENDING -> no commit_done; params_flat returns to the reset values.
